// File: rtl/magnetron_timer_ctrl.sv
// Registered magnetron cooking controller: countdown timer, pause/resume on door open,
// duty-cycled power levels and a one-cycle completion pulse.
module magnetron_timer_ctrl #(
  parameter int unsigned TIME_W       = 8,
  parameter int unsigned TICK_DIV     = 100,
  parameter int unsigned POWER_LEVELS = 10,
  parameter int unsigned PWR_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic [TIME_W-1:0] time_load,
  input  logic [PWR_W-1:0]  power_sel,
  output logic              mag_on,
  output logic [TIME_W-1:0] time_left,
  output logic              cooking,
  output logic              paused,
  output logic              done
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PH_W  = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1;

  localparam logic [PRE_W-1:0]  PreMax   = PRE_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   PhaseMax = PH_W'(POWER_LEVELS - 1);
  localparam logic [PWR_W-1:0]  PwrFull  = PWR_W'(POWER_LEVELS);
  localparam logic [TIME_W-1:0] TimeOne  = TIME_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCook,
    StPause,
    StDone
  } state_e;

  state_e            state_q;
  logic [TIME_W-1:0] time_left_q;
  logic [PRE_W-1:0]  pre_q;
  logic [PH_W-1:0]   phase_q;
  logic [PWR_W-1:0]  power_lat_q;
  logic              cooking_q;
  logic              paused_q;
  logic              done_q;

  // Bit order {clear, stop, start}; buttons idle high, so reset to released.
  logic [2:0] btn_q;
  logic [2:0] btn_prev_q;
  logic [2:0] press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= 3'b111;
      btn_prev_q <= 3'b111;
      press_q    <= 3'b000;
    end else begin
      btn_q      <= {clearn, stopn, startn};
      btn_prev_q <= btn_q;
      press_q    <= btn_prev_q & ~btn_q;
    end
  end

  logic clear_ev;
  logic stop_ev;
  logic start_ev;
  logic abort_ev;
  logic tick;
  logic start_ok;

  always_comb begin
    clear_ev = press_q[2];
    stop_ev  = press_q[1];
    start_ev = press_q[0];
    abort_ev = clear_ev | stop_ev;
    tick     = (state_q == StCook) && (pre_q == PreMax);
    start_ok = start_ev && door_closed && (time_load != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      time_left_q <= '0;
      pre_q       <= '0;
      phase_q     <= '0;
      power_lat_q <= '0;
      cooking_q   <= 1'b0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!abort_ev && start_ok) begin
            state_q     <= StCook;
            time_left_q <= time_load;
            power_lat_q <= (power_sel > PwrFull) ? PwrFull : power_sel;
            pre_q       <= '0;
            phase_q     <= '0;
            cooking_q   <= 1'b1;
          end
        end

        StCook: begin
          if (abort_ev) begin
            state_q     <= StIdle;
            time_left_q <= '0;
            cooking_q   <= 1'b0;
          end else if (!door_closed) begin
            // Any tick landing in this cycle is dropped; phase stays put while paused.
            state_q   <= StPause;
            cooking_q <= 1'b0;
            paused_q  <= 1'b1;
          end else if (tick) begin
            pre_q   <= '0;
            phase_q <= (phase_q == PhaseMax) ? '0 : phase_q + PH_W'(1);
            if (time_left_q == TimeOne) begin
              state_q     <= StDone;
              time_left_q <= '0;
              cooking_q   <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              time_left_q <= time_left_q - TimeOne;
            end
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end

        StPause: begin
          if (abort_ev) begin
            state_q     <= StIdle;
            time_left_q <= '0;
            paused_q    <= 1'b0;
          end else if (start_ev && door_closed) begin
            state_q   <= StCook;
            pre_q     <= '0;
            cooking_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end

        StDone: begin
          if ((press_q != 3'b000) || !door_closed) begin
            state_q     <= StIdle;
            time_left_q <= '0;
          end
        end

        default: begin
          state_q     <= StIdle;
          time_left_q <= '0;
          cooking_q   <= 1'b0;
          paused_q    <= 1'b0;
        end
      endcase
    end
  end

  // Door term is deliberately combinational so the interlock cuts drive in the opening cycle.
  assign mag_on    = cooking_q & (PWR_W'(phase_q) < power_lat_q) & door_closed;
  assign time_left = time_left_q;
  assign cooking   = cooking_q;
  assign paused    = paused_q;
  assign done      = done_q;

endmodule

// File: tb/tb_magnetron_timer_ctrl.sv
// Self-checking bench for magnetron_timer_ctrl: vector table plus hand-written sequences,
// all expectations routed through a scoreboard queue.
module tb_magnetron_timer_ctrl;

  localparam int unsigned TIME_W       = 8;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned POWER_LEVELS = 4;
  localparam int unsigned PWR_W        = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              startn;
  logic              stopn;
  logic              clearn;
  logic              door_closed;
  logic [TIME_W-1:0] time_load;
  logic [PWR_W-1:0]  power_sel;
  logic              mag_on;
  logic [TIME_W-1:0] time_left;
  logic              cooking;
  logic              paused;
  logic              done;

  magnetron_timer_ctrl #(
    .TIME_W      (TIME_W),
    .TICK_DIV    (TICK_DIV),
    .POWER_LEVELS(POWER_LEVELS),
    .PWR_W       (PWR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .time_load  (time_load),
    .power_sel  (power_sel),
    .mag_on     (mag_on),
    .time_left  (time_left),
    .cooking    (cooking),
    .paused     (paused),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic       st;
    logic       c;
    logic       d;
    logic [7:0] tl;
    logic [3:0] ps;
    logic [7:0] n;
    logic [11:0] exp_out;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [11:0] sb_q[$];
  string       sb_name[$];

  function automatic logic [11:0] ev(input logic m, input logic ck, input logic pa,
                                     input logic dn, input logic [7:0] tl);
    return {m, ck, pa, dn, tl};
  endfunction

  function automatic vec_t mk(input logic s, input logic st, input logic c, input logic d,
                              input logic [7:0] tl, input logic [3:0] ps, input logic [7:0] n,
                              input logic [11:0] e);
    vec_t v;
    v.s = s; v.st = st; v.c = c; v.d = d; v.tl = tl; v.ps = ps; v.n = n; v.exp_out = e;
    return v;
  endfunction

  task automatic check_pop();
    logic [11:0] e;
    logic [11:0] a;
    string       nm;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got no entry, want one queued expectation");
    end else begin
      e  = sb_q.pop_front();
      nm = sb_name.pop_front();
      a  = {mag_on, cooking, paused, done, time_left};
      if (a !== e) begin
        bad++;
        $display("FAIL %s @%0t: got mag=%b cook=%b pause=%b done=%b left=%0d, want mag=%b cook=%b pause=%b done=%b left=%0d",
                 nm, $time, a[11], a[10], a[9], a[8], a[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  // n == 0 checks combinational response in the current cycle.
  task automatic expect_after(input int n, input logic [11:0] e, input string nm);
    sb_q.push_back(e);
    sb_name.push_back(nm);
    if (n == 0) begin
      #1;
    end else begin
      repeat (n) @(posedge clk);
      @(negedge clk);
    end
    check_pop();
  endtask

  // One-cycle low pulse; 0 start, 1 stop, 2 clear.
  task automatic pulse(input int which);
    if (which == 0) startn = 1'b0;
    else if (which == 1) stopn = 1'b0;
    else clearn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
  endtask

  task automatic set_job(input logic [7:0] tl, input logic [3:0] ps);
    time_load = tl;
    power_sel = ps;
  endtask

  localparam logic [11:0] Z = 12'h000;

  vec_t vecs[23];

  initial begin
    vecs[0]  = mk(1, 1, 1, 1, 3, 4, 1, Z);
    vecs[1]  = mk(0, 1, 1, 1, 3, 4, 1, Z);
    vecs[2]  = mk(1, 1, 1, 1, 3, 4, 1, Z);
    vecs[3]  = mk(1, 1, 1, 1, 3, 4, 1, ev(1, 1, 0, 0, 3));
    vecs[4]  = mk(1, 1, 1, 1, 3, 4, 3, ev(1, 1, 0, 0, 3));
    vecs[5]  = mk(1, 1, 1, 1, 3, 4, 1, ev(1, 1, 0, 0, 2));
    vecs[6]  = mk(1, 1, 1, 1, 3, 4, 4, ev(1, 1, 0, 0, 1));
    vecs[7]  = mk(1, 1, 1, 1, 3, 4, 3, ev(1, 1, 0, 0, 1));
    vecs[8]  = mk(1, 1, 1, 1, 3, 4, 1, ev(0, 0, 0, 1, 0));
    vecs[9]  = mk(1, 1, 1, 1, 3, 4, 1, Z);
    vecs[10] = mk(1, 1, 0, 1, 3, 4, 1, Z);
    vecs[11] = mk(1, 1, 1, 1, 3, 4, 2, Z);
    vecs[12] = mk(0, 1, 1, 0, 5, 4, 1, Z);   // start with door open
    vecs[13] = mk(1, 1, 1, 0, 5, 4, 3, Z);
    vecs[14] = mk(0, 1, 1, 1, 0, 4, 1, Z);   // start with zero time
    vecs[15] = mk(1, 1, 1, 1, 0, 4, 3, Z);
    vecs[16] = mk(0, 1, 0, 1, 5, 4, 1, Z);   // start and clear together
    vecs[17] = mk(1, 1, 1, 1, 5, 4, 3, Z);
    vecs[18] = mk(0, 1, 1, 1, 5, 4, 3, ev(1, 1, 0, 0, 5));
    vecs[19] = mk(0, 1, 0, 1, 5, 4, 1, ev(1, 1, 0, 0, 5));
    vecs[20] = mk(0, 1, 1, 1, 5, 4, 2, Z);   // clear in COOK at 5
    vecs[21] = mk(0, 1, 1, 1, 5, 4, 4, Z);   // start still held
    vecs[22] = mk(1, 1, 1, 1, 5, 4, 3, Z);   // release is not a press

    rst = 1'b1;
    startn = 1'b1;
    stopn = 1'b1;
    clearn = 1'b1;
    door_closed = 1'b1;
    set_job(8'd0, 4'd0);
    @(negedge clk);
    expect_after(0, Z, "in_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      startn      = vecs[i].s;
      stopn       = vecs[i].st;
      clearn      = vecs[i].c;
      door_closed = vecs[i].d;
      set_job(vecs[i].tl, vecs[i].ps);
      expect_after(int'(vecs[i].n), vecs[i].exp_out, $sformatf("vec%0d", i));
    end

    // Half power: 1,1,0,0 per second, 32 cycles to DONE.
    set_job(8'd8, 4'd2);
    pulse(0);
    expect_after(1, Z, "half_pre");
    for (int k = 0; k < 32; k++) begin
      int sec;
      sec = k / 4;
      expect_after(1, ev((sec % 4) < 2, 1, 0, 0, 8'(8 - sec)), $sformatf("half_k%0d", k));
    end
    expect_after(1, ev(0, 0, 0, 1, 0), "half_done");
    pulse(2);
    expect_after(2, Z, "half_clear");

    // Door interlock and resume.
    set_job(8'd3, 4'd4);
    pulse(0);
    expect_after(2, ev(1, 1, 0, 0, 3), "door_cook");
    expect_after(4, ev(1, 1, 0, 0, 2), "door_at2");
    door_closed = 1'b0;
    expect_after(0, ev(0, 1, 0, 0, 2), "door_mag_cut");
    expect_after(1, ev(0, 0, 1, 0, 2), "door_paused");
    door_closed = 1'b1;
    expect_after(3, ev(0, 0, 1, 0, 2), "door_closed_still_paused");
    pulse(0);
    expect_after(1, ev(0, 0, 1, 0, 2), "resume_pre");
    expect_after(1, ev(1, 1, 0, 0, 2), "resume_cook");
    expect_after(4, ev(1, 1, 0, 0, 1), "resume_at1");
    expect_after(3, ev(1, 1, 0, 0, 1), "resume_last");
    expect_after(1, ev(0, 0, 0, 1, 0), "resume_done");
    pulse(2);
    expect_after(2, Z, "resume_clear");

    // Stop while paused.
    set_job(8'd4, 4'd4);
    pulse(0);
    expect_after(2, ev(1, 1, 0, 0, 4), "stp_cook");
    door_closed = 1'b0;
    expect_after(1, ev(0, 0, 1, 0, 4), "stp_paused");
    pulse(1);
    expect_after(1, ev(0, 0, 1, 0, 4), "stp_pre");
    expect_after(1, Z, "stop_in_pause");
    door_closed = 1'b1;

    // Power 0: timer runs, magnetron stays off.
    set_job(8'd1, 4'd0);
    pulse(0);
    expect_after(2, ev(0, 1, 0, 0, 1), "pwr0_cook");
    expect_after(4, ev(0, 0, 0, 1, 0), "pwr0_done");
    pulse(2);
    expect_after(2, Z, "pwr0_clear");

    // Asynchronous reset mid-cook, then a fresh cook.
    set_job(8'd6, 4'd4);
    pulse(0);
    expect_after(2, ev(1, 1, 0, 0, 6), "rst_cook");
    expect_after(8, ev(1, 1, 0, 0, 4), "rst_at4");
    rst = 1'b1;
    expect_after(0, Z, "rst_async");
    expect_after(1, Z, "rst_held");
    rst = 1'b0;
    set_job(8'd2, 4'd4);
    pulse(0);
    expect_after(2, ev(1, 1, 0, 0, 2), "fresh_cook");
    expect_after(8, ev(0, 0, 0, 1, 0), "fresh_done");

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
